// File: rtl/md_sched.sv
// ---------------------------------------------------------------------------
// md_sched -- multi-cycle multiply/divide scheduler with HI/LO registers.
//
// Accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO request from EX while idle.
// The arithmetic result is computed in the issue cycle and parked in a
// pending register. A busy countdown then models the unit's latency, and the
// result commits to HI/LO when the countdown ends. A stall request freezes
// IF/ID while an MDU-dependent instruction sits in ID.
//
// Parameters:
//   MULT_CYCLES  busy cycles for MULT/MULTU (1..15)
//   DIV_CYCLES   busy cycles for DIV/DIVU   (1..15)
//
// Ports:
//   clk        system clock, all state updates on posedge
//   reset      synchronous active-low reset (0 = reset)
//   start      request valid from EX this cycle
//   op         0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 ignored
//   opA, opB   forwarded rs / rt values
//   md_use_ID  instruction in ID touches the MDU
//   busy       operation in progress
//   done       one-cycle pulse after a result commits to HI/LO
//   stall_ID   stall request to the IF/ID pipeline registers
//   hi, lo     architectural HI/LO registers
// ---------------------------------------------------------------------------
module md_sched #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] opA,
   input  logic [31:0] opB,
   input  logic        md_use_ID,
   output logic        busy,
   output logic        done,
   output logic        stall_ID,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   localparam logic [3:0] LP_MULT_CNT = 4'(MULT_CYCLES);
   localparam logic [3:0] LP_DIV_CNT  = 4'(DIV_CYCLES);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [3:0]  r_cnt, w_cnt_nxt;
   logic [31:0] r_pend_hi, w_pend_hi_nxt;
   logic [31:0] r_pend_lo, w_pend_lo_nxt;
   logic [31:0] r_hi, w_hi_nxt;
   logic [31:0] r_lo, w_lo_nxt;
   logic        r_done, w_done_nxt;

   // Arithmetic datapath, evaluated on the issue-cycle operands.
   logic signed [63:0] w_prod_s;
   logic        [63:0] w_prod_u;
   logic signed [31:0] w_quo_s, w_rem_s;
   logic        [31:0] w_quo_u, w_rem_u;
   logic               w_div_zero;
   logic               w_div_ovf;

   assign w_prod_s   = 64'($signed(opA)) * 64'($signed(opB));
   assign w_prod_u   = 64'(opA) * 64'(opB);
   assign w_quo_s    = $signed(opA) / $signed(opB);
   assign w_rem_s    = $signed(opA) % $signed(opB);
   assign w_quo_u    = opA / opB;
   assign w_rem_u    = opA % opB;
   assign w_div_zero = (opB == 32'd0);
   // Most-negative / -1 overflows 32 bits; it wraps to the dividend with a
   // zero remainder rather than relying on the divider's corner behaviour.
   assign w_div_ovf  = (opA == 32'h8000_0000) && (opB == 32'hFFFF_FFFF);

   // NOTE: every signal assigned below gets a default first so that no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_pend_hi_nxt = r_pend_hi;
      w_pend_lo_nxt = r_pend_lo;
      w_hi_nxt      = r_hi;
      w_lo_nxt      = r_lo;
      w_done_nxt    = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               unique case (op)
                  OP_MULT: begin
                     {w_pend_hi_nxt, w_pend_lo_nxt} = w_prod_s;
                     w_cnt_nxt   = LP_MULT_CNT;
                     w_state_nxt = S_BUSY;
                  end
                  OP_MULTU: begin
                     {w_pend_hi_nxt, w_pend_lo_nxt} = w_prod_u;
                     w_cnt_nxt   = LP_MULT_CNT;
                     w_state_nxt = S_BUSY;
                  end
                  OP_DIV: begin
                     // Divide by zero still occupies the unit but reloads the
                     // current HI/LO, so the commit leaves them unchanged.
                     if (w_div_zero) begin
                        w_pend_hi_nxt = r_hi;
                        w_pend_lo_nxt = r_lo;
                     end else if (w_div_ovf) begin
                        w_pend_hi_nxt = 32'd0;
                        w_pend_lo_nxt = 32'h8000_0000;
                     end else begin
                        w_pend_hi_nxt = w_rem_s;
                        w_pend_lo_nxt = w_quo_s;
                     end
                     w_cnt_nxt   = LP_DIV_CNT;
                     w_state_nxt = S_BUSY;
                  end
                  OP_DIVU: begin
                     if (w_div_zero) begin
                        w_pend_hi_nxt = r_hi;
                        w_pend_lo_nxt = r_lo;
                     end else begin
                        w_pend_hi_nxt = w_rem_u;
                        w_pend_lo_nxt = w_quo_u;
                     end
                     w_cnt_nxt   = LP_DIV_CNT;
                     w_state_nxt = S_BUSY;
                  end
                  OP_MTHI: w_hi_nxt = opA;
                  OP_MTLO: w_lo_nxt = opA;
                  default: ;
               endcase
            end
         end

         S_BUSY: begin
            // Requests arriving here are dropped; upstream stalls prevent them.
            if (r_cnt == 4'd1) begin
               w_hi_nxt    = r_pend_hi;
               w_lo_nxt    = r_pend_lo;
               w_cnt_nxt   = 4'd0;
               w_done_nxt  = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end

         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   // NOTE: the pending registers are cleared on reset as well, so an aborted
   // result can never leak into HI/LO later.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= 4'd0;
         r_pend_hi <= 32'd0;
         r_pend_lo <= 32'd0;
         r_hi      <= 32'd0;
         r_lo      <= 32'd0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_pend_hi <= w_pend_hi_nxt;
         r_pend_lo <= w_pend_lo_nxt;
         r_hi      <= w_hi_nxt;
         r_lo      <= w_lo_nxt;
         r_done    <= w_done_nxt;
      end
   end

   assign busy = (r_state == S_BUSY);
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

   // The issue cycle is covered too: the dependent instruction in ID must not
   // advance while its predecessor is just entering the unit.
   assign stall_ID = md_use_ID & (busy | (start & (op <= OP_DIVU)));

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Multi-cycle multiply/divide scheduler for the 5-stage pipeline.
- Accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO request per operation from the EX stage and holds the HI/LO result registers.
- Models fixed operation latency with a busy countdown.
- Produces the stall request that the hazard logic uses to freeze IF/ID while an MDU-dependent instruction sits in ID.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15).

Ports:
- clk  input  1  system clock, all state updates on posedge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- start  input  1  request valid from EX this cycle.
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are ignored.
- opA  input  32  forwarded rs value from EX.
- opB  input  32  forwarded rt value from EX.
- md_use_ID  input  1  instruction in ID is mult/div/mfhi/mflo/mthi/mtlo.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when a result commits to HI/LO.
- stall_ID  output  1  stall request to IF/ID pipeline registers.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (reset==0 at a posedge): state goes to IDLE, counter=0, hi=0, lo=0, pending result=0, busy=0, done=0. Reset overrides everything, including a start in the same cycle and an operation already in progress; the aborted result is discarded.
- States: IDLE, BUSY.
- IDLE with start=1 and op in {0..3}:
  - Compute the 64-bit result combinationally from opA/opB and latch it into pending_hi/pending_lo.
  - Load counter = MULT_CYCLES or DIV_CYCLES, then go to BUSY.
- IDLE with start=1 and op=4/5: write opA into hi or lo at that edge. No busy, no done. The state stays IDLE.
- IDLE with start=1 and op=6/7: no effect.
- BUSY: decrement the counter each cycle. At the edge where the counter equals 1:
  - copy pending into hi/lo,
  - set counter=0,
  - return to IDLE,
  - register done=1 for exactly the following cycle.
- start while BUSY is ignored and does not queue. Upstream guarantees this never happens through stall_ID; the bench checks it as a protocol assertion.
- Timing for start sampled at edge T with N cycles: busy=1 during cycles T+1..T+N. hi/lo show the new value from T+N+1 onward. done=1 during cycle T+N+1 only. hi/lo keep their old values throughout BUSY.
- busy is registered and equals (state==BUSY).
- stall_ID is combinational: md_use_ID & (busy | (start & op<=3)). This covers the cycle in which the operation is issued.
- MULT: signed 32x32 to 64. hi=result[63:32], lo=result[31:0].
- MULTU: the same as MULT but unsigned.
- DIV: signed. lo=quotient, truncated toward zero. hi=remainder, carrying the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned. lo=quotient, hi=remainder.
- Divide by zero (opB==0, DIV or DIVU): busy for the full DIV_CYCLES and done still pulses. hi/lo stay unchanged because pending is loaded from the current hi/lo.
- Back-to-back issue: a new start is accepted in the same cycle that done is high, because the state is IDLE by then.

Test Plan:
- MULT, opA=0xFFFFFFFD, opB=5: busy high for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1, done pulses once.
- MULTU, opA=0xFFFFFFFF, opB=2: hi=0x00000001, lo=0xFFFFFFFE.
- DIVU 100/7: busy for 10 cycles, then lo=14, hi=2.
- DIV, opA=0xFFFFFFF9 (-7), opB=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero after hi=0x11, lo=0x22 (set via MTHI/MTLO): busy for 10 cycles, then hi/lo still 0x11/0x22 and done pulses.
- Stall:
  - md_use_ID=1 in the start cycle and all 5 MULT busy cycles gives stall_ID=1.
  - In the done cycle stall_ID=0.
  - With md_use_ID=0, stall_ID stays 0 throughout.
- MTHI with opA=0xDEADBEEF while IDLE: hi=0xDEADBEEF the next cycle, busy stays 0, no done pulse.
- Reset mid-op: DIV started, reset=0 at busy cycle 4 gives busy=0, hi=lo=0 and no done pulse. A following MULT 3*4 completes normally with lo=12.
- Start while BUSY: a second start during busy cycle 2 is ignored, and only the first result commits.
